exu_mdu_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared, non-pipelined integer multiply/divide unit (MDU). It accepts MDU operations from two issue lanes using valid/ready handshakes and grants them round-robin. It drives the single MDU issue port, tracks the owner of the in-flight operation and steers the MDU result back as a tagged completion. It also handles pipeline flush, because the MDU cannot abort an operation in flight, and runs a busy watchdog.

---
 rtl/exu_mdu_arb_pkg.sv | 23 ++
 rtl/exu_mdu_arb_if.sv | 55 +++++
 rtl/exu_mdu_arb_rr_arb2.sv | 33 +++
 rtl/exu_mdu_arb.sv | 130 +++++++++++++
 tb/tb_exu_mdu_arb.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_mdu_arb_pkg.sv
// Shared definitions for the MDU arbiter: FSM state encoding, op-field width
// and the one-hot op bit positions used by the MDU op field.
package exu_mdu_arb_pkg;

  localparam int unsigned MDU_INFOW = 8;

  // Bit positions inside the one-hot MDU op field
  localparam int unsigned MDU_MUL    = 0;
  localparam int unsigned MDU_MULH   = 1;
  localparam int unsigned MDU_MULHU  = 2;
  localparam int unsigned MDU_MULHSU = 3;
  localparam int unsigned MDU_DIV    = 4;
  localparam int unsigned MDU_DIVU   = 5;
  localparam int unsigned MDU_REM    = 6;
  localparam int unsigned MDU_REMU   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/exu_mdu_arb_if.sv
// Bundle of request, MDU issue/result, completion and status signals of the
// MDU arbiter. The slave modport is the arbiter's view, master the environment's.
interface exu_mdu_arb_if
  import exu_mdu_arb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RFIDXW = 5,
  parameter int unsigned INFOW  = MDU_INFOW
);

  logic [1:0]          i_req_vld;
  logic [1:0]          o_req_rdy;
  logic [2*INFOW-1:0]  i_req_info;
  logic [1:0]          i_req_rdwen;
  logic [2*RFIDXW-1:0] i_req_rdidx;
  logic [2*XLEN-1:0]   i_req_op1;
  logic [2*XLEN-1:0]   i_req_op2;
  logic                i_flush;

  logic                o_mdu_vld;
  logic [INFOW-1:0]    o_mdu_info;
  logic                o_mdu_rdwen;
  logic [RFIDXW-1:0]   o_mdu_rdidx;
  logic [XLEN-1:0]     o_mdu_op1;
  logic [XLEN-1:0]     o_mdu_op2;
  logic                i_mdu_finish;
  logic [XLEN-1:0]     i_mdu_rdwdata;

  logic [1:0]          o_cpl_vld;
  logic                o_cpl_rdwen;
  logic [RFIDXW-1:0]   o_cpl_rdidx;
  logic [XLEN-1:0]     o_cpl_rdwdata;

  logic                o_busy;
  logic                o_err;

  modport slave (
    input  i_req_vld, i_req_info, i_req_rdwen, i_req_rdidx, i_req_op1, i_req_op2,
    input  i_flush, i_mdu_finish, i_mdu_rdwdata,
    output o_req_rdy,
    output o_mdu_vld, o_mdu_info, o_mdu_rdwen, o_mdu_rdidx, o_mdu_op1, o_mdu_op2,
    output o_cpl_vld, o_cpl_rdwen, o_cpl_rdidx, o_cpl_rdwdata,
    output o_busy, o_err
  );

  modport master (
    output i_req_vld, i_req_info, i_req_rdwen, i_req_rdidx, i_req_op1, i_req_op2,
    output i_flush, i_mdu_finish, i_mdu_rdwdata,
    input  o_req_rdy,
    input  o_mdu_vld, o_mdu_info, o_mdu_rdwen, o_mdu_rdidx, o_mdu_op1, o_mdu_op2,
    input  o_cpl_vld, o_cpl_rdwen, o_cpl_rdidx, o_cpl_rdwdata,
    input  o_busy, o_err
  );

endinterface

// File: rtl/exu_mdu_arb_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the lane that wins a tie and
// moves to the other lane only when the current grant is consumed (adv_i).
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] grant_o
);

  logic rr_q, rr_d;

  always_comb begin
    grant_o = '0;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = rr_q ? 2'b10 : 2'b01;
      default: grant_o = '0;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (adv_i) rr_d = ~grant_o[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/exu_mdu_arb.sv
// Arbiter/sequencer for the shared non-pipelined MDU: round-robin issue from two
// lanes, owner tracking, tagged completion, flush draining and a busy watchdog.
module exu_mdu_arb
  import exu_mdu_arb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RFIDXW  = 5,
  parameter int unsigned INFOW   = MDU_INFOW,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic          i_clk,
  input  logic          i_rst,
  exu_mdu_arb_if.slave  bus
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rdwen_q, rdwen_d;
  logic [RFIDXW-1:0] rdidx_q, rdidx_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic              err_q, err_d;

  logic [1:0] grant;
  logic [1:0] rdy;
  logic       accept;
  logic       sel;
  logic       idle;

  rr_arb2 u_rr_arb2 (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .req_i   (bus.i_req_vld),
    .adv_i   (accept),
    .grant_o (grant)
  );

  assign idle   = (state_q == ST_IDLE);
  assign rdy    = grant & {2{idle & ~bus.i_flush}};
  assign accept = |rdy;
  assign sel    = grant[1];

  // Issue payload is muxed straight from the granted lane (zero-latency issue)
  always_comb begin
    if (sel) begin
      bus.o_mdu_info  = bus.i_req_info[2*INFOW-1:INFOW];
      bus.o_mdu_rdwen = bus.i_req_rdwen[1];
      bus.o_mdu_rdidx = bus.i_req_rdidx[2*RFIDXW-1:RFIDXW];
      bus.o_mdu_op1   = bus.i_req_op1[2*XLEN-1:XLEN];
      bus.o_mdu_op2   = bus.i_req_op2[2*XLEN-1:XLEN];
    end else begin
      bus.o_mdu_info  = bus.i_req_info[INFOW-1:0];
      bus.o_mdu_rdwen = bus.i_req_rdwen[0];
      bus.o_mdu_rdidx = bus.i_req_rdidx[RFIDXW-1:0];
      bus.o_mdu_op1   = bus.i_req_op1[XLEN-1:0];
      bus.o_mdu_op2   = bus.i_req_op2[XLEN-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A finish always retires the op; flush only decides whether it is reported
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_BUSY;
      ST_BUSY: begin
        if (bus.i_mdu_finish)  state_d = ST_IDLE;
        else if (bus.i_flush)  state_d = ST_DRAIN;
      end
      ST_DRAIN: if (bus.i_mdu_finish) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_req_rdy     = rdy;
    bus.o_mdu_vld     = accept;
    bus.o_cpl_vld     = '0;
    if ((state_q == ST_BUSY) && bus.i_mdu_finish && !bus.i_flush)
      bus.o_cpl_vld = owner_q ? 2'b10 : 2'b01;
    bus.o_cpl_rdwen   = rdwen_q;
    bus.o_cpl_rdidx   = rdidx_q;
    bus.o_cpl_rdwdata = bus.i_mdu_rdwdata;
    bus.o_busy        = !idle;
    bus.o_err         = err_q;
  end

  always_comb begin
    owner_d = owner_q;
    rdwen_d = rdwen_q;
    rdidx_d = rdidx_q;
    if (accept) begin
      owner_d = sel;
      rdwen_d = bus.o_mdu_rdwen;
      rdidx_d = bus.o_mdu_rdidx;
    end
  end

  // Watchdog saturates at TIMEOUT; the error flag is sticky until reset
  always_comb begin
    wdog_d = wdog_q;
    if (accept)
      wdog_d = '0;
    else if (!idle && (wdog_q != WDW'(TIMEOUT)))
      wdog_d = wdog_q + 1'b1;
    err_d = err_q | (!idle && (wdog_d == WDW'(TIMEOUT)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q <= 1'b0;
      rdwen_q <= 1'b0;
      rdidx_q <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      rdwen_q <= rdwen_d;
      rdidx_q <= rdidx_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_exu_mdu_arb.sv
// Directed bench for exu_mdu_arb: single op, contention, flush/drain, watchdog
// and asynchronous reset, with hand-computed expectations.
module tb_exu_mdu_arb;
  import exu_mdu_arb_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RFIDXW = 5;
  localparam int unsigned INFOW  = MDU_INFOW;

  logic        clk;
  logic        rst;
  int unsigned total;
  int unsigned bad;

  exu_mdu_arb_if #(.XLEN(XLEN), .RFIDXW(RFIDXW), .INFOW(INFOW)) bus ();

  exu_mdu_arb #(
    .XLEN    (XLEN),
    .RFIDXW  (RFIDXW),
    .INFOW   (INFOW),
    .TIMEOUT (63)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lane(input int unsigned k, input logic [7:0] info, input logic wen,
                            input logic [4:0] idx, input logic [31:0] a, input logic [31:0] b);
    bus.i_req_info[k*INFOW +: INFOW]    = info;
    bus.i_req_rdwen[k]                  = wen;
    bus.i_req_rdidx[k*RFIDXW +: RFIDXW] = idx;
    bus.i_req_op1[k*XLEN +: XLEN]       = a;
    bus.i_req_op2[k*XLEN +: XLEN]       = b;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.i_req_vld      = '0;
    bus.i_req_info     = '0;
    bus.i_req_rdwen    = '0;
    bus.i_req_rdidx    = '0;
    bus.i_req_op1      = '0;
    bus.i_req_op2      = '0;
    bus.i_flush        = 1'b0;
    bus.i_mdu_finish   = 1'b0;
    bus.i_mdu_rdwdata  = '0;
    repeat (2) step();
    rst = 1'b0;
    #1;
  endtask

  logic [7:0] op_mul;
  logic [7:0] op_div;

  initial begin
    total  = 0;
    bad    = 0;
    op_mul = 8'(1 << MDU_MUL);
    op_div = 8'(1 << MDU_DIV);

    // Reset values
    do_reset();
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_cpl", bus.o_cpl_vld, 0);
    chk("rst_mdu_vld", bus.o_mdu_vld, 0);
    chk("rst_rdy", bus.o_req_rdy, 0);
    chk("rst_cpl_idx", bus.o_cpl_rdidx, 0);

    // Single op: lane0 mul 7*6, finish two cycles after issue
    drive_lane(0, op_mul, 1'b1, 5'd9, 32'd7, 32'd6);
    bus.i_req_vld = 2'b01;
    #1;
    chk("s_rdy", bus.o_req_rdy, 2'b01);
    chk("s_mdu_vld", bus.o_mdu_vld, 1);
    chk("s_op1", bus.o_mdu_op1, 7);
    chk("s_op2", bus.o_mdu_op2, 6);
    chk("s_info", bus.o_mdu_info, 8'h01);
    chk("s_idx", bus.o_mdu_rdidx, 9);
    step();
    bus.i_req_vld = 2'b00;
    #1;
    chk("s_busy", bus.o_busy, 1);
    chk("s_mdu_vld_off", bus.o_mdu_vld, 0);
    step();
    chk("s_no_cpl_early", bus.o_cpl_vld, 0);
    step();
    bus.i_mdu_finish  = 1'b1;
    bus.i_mdu_rdwdata = 32'd42;
    #1;
    chk("s_cpl", bus.o_cpl_vld, 2'b01);
    chk("s_cpl_data", bus.o_cpl_rdwdata, 42);
    chk("s_cpl_idx", bus.o_cpl_rdidx, 9);
    chk("s_cpl_wen", bus.o_cpl_rdwen, 1);
    step();
    bus.i_mdu_finish = 1'b0;
    #1;
    chk("s_idle", bus.o_busy, 0);
    chk("s_cpl_off", bus.o_cpl_vld, 0);

    // Contention from reset: lane0, lane1, lane0
    do_reset();
    drive_lane(0, op_mul, 1'b1, 5'd1, 32'd100, 32'd1);
    drive_lane(1, op_mul, 1'b1, 5'd2, 32'd200, 32'd2);
    bus.i_req_vld = 2'b11;
    #1;
    chk("c1_rdy", bus.o_req_rdy, 2'b01);
    chk("c1_op1", bus.o_mdu_op1, 100);
    step();
    chk("c1_busy_rdy", bus.o_req_rdy, 2'b00);
    step();
    bus.i_mdu_finish  = 1'b1;
    bus.i_mdu_rdwdata = 32'd11;
    #1;
    chk("c1_cpl", bus.o_cpl_vld, 2'b01);
    chk("c1_cpl_idx", bus.o_cpl_rdidx, 1);
    step();
    bus.i_mdu_finish = 1'b0;
    #1;
    chk("c2_rdy", bus.o_req_rdy, 2'b10);
    chk("c2_op1", bus.o_mdu_op1, 200);
    chk("c2_idx", bus.o_mdu_rdidx, 2);
    step();
    bus.i_mdu_finish  = 1'b1;
    bus.i_mdu_rdwdata = 32'd22;
    #1;
    chk("c2_cpl", bus.o_cpl_vld, 2'b10);
    chk("c2_cpl_idx", bus.o_cpl_rdidx, 2);
    chk("c2_cpl_data", bus.o_cpl_rdwdata, 22);
    step();
    bus.i_mdu_finish = 1'b0;
    #1;
    chk("c3_rdy", bus.o_req_rdy, 2'b01);
    step();
    bus.i_req_vld    = 2'b00;
    bus.i_mdu_finish = 1'b1;
    #1;
    chk("c3_cpl", bus.o_cpl_vld, 2'b01);
    step();
    bus.i_mdu_finish = 1'b0;

    // Flush in BUSY: div issued at cycle 0, flush at 5, finish at 34
    do_reset();
    drive_lane(0, op_div, 1'b1, 5'd4, 32'd100, 32'd7);
    drive_lane(1, op_mul, 1'b1, 5'd5, 32'd3, 32'd3);
    bus.i_req_vld = 2'b01;
    #1;
    chk("f_rdy", bus.o_req_rdy, 2'b01);
    chk("f_info", bus.o_mdu_info, 8'h10);
    step();
    bus.i_req_vld = 2'b10;
    repeat (4) step();
    bus.i_flush = 1'b1;
    #1;
    chk("f_flush_cpl", bus.o_cpl_vld, 0);
    chk("f_flush_rdy", bus.o_req_rdy, 0);
    step();
    chk("f_drain_busy", bus.o_busy, 1);
    chk("f_drain_rdy", bus.o_req_rdy, 0);
    step();
    bus.i_flush = 1'b0;
    repeat (27) step();
    bus.i_mdu_finish  = 1'b1;
    bus.i_mdu_rdwdata = 32'd14;
    #1;
    chk("f_drain_cpl", bus.o_cpl_vld, 0);
    chk("f_drain_rdy_fin", bus.o_req_rdy, 0);
    chk("f_err", bus.o_err, 0);
    step();
    bus.i_mdu_finish = 1'b0;
    #1;
    chk("f_after_rdy", bus.o_req_rdy, 2'b10);
    chk("f_after_vld", bus.o_mdu_vld, 1);
    chk("f_after_op1", bus.o_mdu_op1, 3);
    step();

    // Flush coincident with finish: no completion, IDLE next cycle
    bus.i_req_vld    = 2'b00;
    bus.i_mdu_finish = 1'b1;
    bus.i_flush      = 1'b1;
    #1;
    chk("ff_cpl", bus.o_cpl_vld, 0);
    step();
    bus.i_mdu_finish = 1'b0;
    bus.i_flush      = 1'b0;
    #1;
    chk("ff_idle", bus.o_busy, 0);

    // Flush in IDLE blocks both lanes
    drive_lane(0, op_mul, 1'b1, 5'd7, 32'd1, 32'd1);
    bus.i_req_vld = 2'b11;
    bus.i_flush   = 1'b1;
    #1;
    chk("fi_rdy", bus.o_req_rdy, 0);
    chk("fi_mdu_vld", bus.o_mdu_vld, 0);
    step();
    bus.i_flush = 1'b0;
    #1;
    chk("fi_idle", bus.o_busy, 0);
    chk("fi_rr_rdy", bus.o_req_rdy, 2'b01);

    // Watchdog: lane0 accepted, finish withheld
    bus.i_req_vld = 2'b01;
    #1;
    chk("w_rdy", bus.o_req_rdy, 2'b01);
    step();
    bus.i_req_vld = 2'b00;
    repeat (62) step();
    chk("w_err_62", bus.o_err, 0);
    chk("w_busy_62", bus.o_busy, 1);
    step();
    chk("w_err_63", bus.o_err, 1);
    chk("w_busy_63", bus.o_busy, 1);
    bus.i_mdu_finish  = 1'b1;
    bus.i_mdu_rdwdata = 32'd5;
    #1;
    chk("w_cpl", bus.o_cpl_vld, 2'b01);
    chk("w_cpl_idx", bus.o_cpl_rdidx, 7);
    step();
    bus.i_mdu_finish = 1'b0;
    #1;
    chk("w_err_sticky", bus.o_err, 1);
    chk("w_idle", bus.o_busy, 0);

    // Async reset mid-BUSY, then a stray finish
    bus.i_req_vld = 2'b01;
    step();
    bus.i_req_vld = 2'b00;
    step();
    chk("r_busy_pre", bus.o_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_busy", bus.o_busy, 0);
    chk("r_err", bus.o_err, 0);
    chk("r_cpl", bus.o_cpl_vld, 0);
    chk("r_mdu_vld", bus.o_mdu_vld, 0);
    chk("r_cpl_idx", bus.o_cpl_rdidx, 0);
    #1;
    rst = 1'b0;
    step();
    bus.i_mdu_finish = 1'b1;
    #1;
    chk("r_stray_cpl", bus.o_cpl_vld, 0);
    chk("r_stray_busy", bus.o_busy, 0);
    step();
    bus.i_mdu_finish = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
